// File: rtl/util_adc_pack_if.sv
// Sample-in / packed-word-out bus between the ADC core, util_adc_pack and the DMA write FIFO.
interface util_adc_pack_if #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned DATA_WIDTH   = 16
);
  localparam int unsigned WORD_W = NUM_CHANNELS * DATA_WIDTH;

  logic [NUM_CHANNELS-1:0] adc_enable;
  logic                    adc_valid;
  logic [WORD_W-1:0]       adc_data;
  logic                    packed_ready;
  logic                    packed_wr_en;
  logic [WORD_W-1:0]       packed_data;
  logic                    packed_sync;
  logic                    adc_dovf;

  // Core/FIFO side: supplies samples and ready, observes packed words.
  modport master (
    output adc_enable, adc_valid, adc_data, packed_ready,
    input  packed_wr_en, packed_data, packed_sync, adc_dovf
  );

  // Packer side.
  modport slave (
    input  adc_enable, adc_valid, adc_data, packed_ready,
    output packed_wr_en, packed_data, packed_sync, adc_dovf
  );
endinterface

// File: rtl/util_adc_pack.sv
// util_adc_pack: compacts enabled ADC channels into full-width words for the DMA write FIFO.
// Optional 16-bit saturating drop counter under `define UTIL_ADC_PACK_DROP_COUNT_EN.
module util_adc_pack #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic            adc_clk,
  input  logic            adc_rst,
  util_adc_pack_if.slave  bus
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
  ,
  output logic [15:0]     drop_count
`endif
);
  localparam int unsigned WORD_W = NUM_CHANNELS * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(NUM_CHANNELS + 1);
  localparam int unsigned PTR_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0] en_q;
  logic [PTR_W-1:0]        p_q, p_d;
  logic [WORD_W-1:0]       asm_q, asm_d;
  logic                    sync_arm_q, sync_arm_d;
  logic                    wr_en_q, wr_en_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    sync_q, sync_d;
  logic                    dovf_q, dovf_d;
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
  localparam int unsigned DROP_W = 16;
  logic [DROP_W-1:0]       drop_q, drop_d;
`endif

  logic [CNT_W-1:0]        n_c;
  logic                    en_chg_c;
  logic                    pow2_c;
  logic                    accept_c;
  logic                    complete_c;
  logic [WORD_W-1:0]       comp_c;
  logic [WORD_W-1:0]       word_c;
  int unsigned             k;

  // Next-state: compaction, slot placement, word completion and emit/drop decision.
  always_comb begin
    p_d        = p_q;
    asm_d      = asm_q;
    sync_arm_d = sync_arm_q;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    sync_d     = 1'b0;
    dovf_d     = 1'b0;
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
    drop_d     = drop_q;
`endif
    comp_c     = '0;
    word_c     = '0;
    complete_c = 1'b0;
    k          = 0;

    n_c      = CNT_W'($countones(bus.adc_enable));
    en_chg_c = (bus.adc_enable != en_q);
    pow2_c   = (n_c != '0) && ((n_c & (n_c - CNT_W'(1))) == '0);
    accept_c = bus.adc_valid && !en_chg_c && (n_c != '0);

    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (bus.adc_enable[i]) begin
        comp_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.adc_data[i*DATA_WIDTH +: DATA_WIDTH];
        k = k + 1;
      end
    end

    if (en_chg_c) begin
      p_d        = '0;
      sync_arm_d = 1'b1;
    end else if (accept_c) begin
      if (pow2_c) begin
        word_c = asm_q;
        for (int unsigned j = 0; j < NUM_CHANNELS; j++) begin
          if ((j < 32'(n_c)) && ((32'(p_q) + j) < NUM_CHANNELS))
            word_c[(32'(p_q) + j)*DATA_WIDTH +: DATA_WIDTH] = comp_c[j*DATA_WIDTH +: DATA_WIDTH];
        end
        complete_c = ((32'(p_q) + 32'(n_c)) == NUM_CHANNELS);
        asm_d      = word_c;
        p_d        = complete_c ? '0 : PTR_W'(32'(p_q) + 32'(n_c));
      end else begin
        // Non power-of-two channel sets are zero-padded to one word per set.
        word_c     = comp_c;
        complete_c = 1'b1;
      end

      if (complete_c) begin
        if (bus.packed_ready) begin
          wr_en_d    = 1'b1;
          data_d     = word_c;
          sync_d     = sync_arm_q;
          sync_arm_d = 1'b0;
        end else begin
          dovf_d = 1'b1;
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
          if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
`endif
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      en_q       <= '0;
      p_q        <= '0;
      asm_q      <= '0;
      sync_arm_q <= 1'b1;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      sync_q     <= 1'b0;
      dovf_q     <= 1'b0;
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
      drop_q     <= '0;
`endif
    end else begin
      en_q       <= bus.adc_enable;
      p_q        <= p_d;
      asm_q      <= asm_d;
      sync_arm_q <= sync_arm_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      sync_q     <= sync_d;
      dovf_q     <= dovf_d;
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
      drop_q     <= drop_d;
`endif
    end
  end

  assign bus.packed_wr_en = wr_en_q;
  assign bus.packed_data  = data_q;
  assign bus.packed_sync  = sync_q;
  assign bus.adc_dovf     = dovf_q;
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
  assign drop_count       = drop_q;
`endif

endmodule

// File: tb/tb_util_adc_pack.sv
// Self-checking bench for util_adc_pack (4 x 16-bit): directed plan scenarios plus random traffic
// against a queue-based reference model. Drop-count checks apply when UTIL_ADC_PACK_DROP_COUNT_EN is set.
module tb_util_adc_pack;
  localparam int unsigned NC = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned WW = NC * DW;

  logic adc_clk = 1'b0;
  logic adc_rst = 1'b1;
  always #5 adc_clk = ~adc_clk;

  util_adc_pack_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) bus ();

`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  util_adc_pack #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) dut (
    .adc_clk    (adc_clk),
    .adc_rst    (adc_rst),
    .bus        (bus)
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: samples waiting for a full word, plus expected registered outputs.
  logic [DW-1:0] pend[$];
  logic [NC-1:0] m_en_prev;
  logic          m_armed;
  logic          exp_wr, exp_sync, exp_dovf;
  logic [WW-1:0] exp_data;
  int unsigned   exp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic [NC-1:0] en, input logic valid,
                       input logic [WW-1:0] data, input logic ready);
    logic [DW-1:0] s[$];
    logic [WW-1:0] word;
    int  n;
    bit  done;
    exp_wr   = 1'b0;
    exp_sync = 1'b0;
    exp_dovf = 1'b0;
    if (rst) begin
      pend.delete();
      m_en_prev = '0;
      m_armed   = 1'b1;
      exp_data  = '0;
      exp_cnt   = 0;
      return;
    end
    n = $countones(en);
    if (en != m_en_prev) begin
      m_en_prev = en;
      pend.delete();
      m_armed = 1'b1;
      return;
    end
    if (!valid || n == 0) return;
    for (int i = 0; i < NC; i++)
      if (en[i]) s.push_back(data[i*DW +: DW]);
    word = '0;
    done = 1'b0;
    if (n == 1 || n == 2 || n == 4 || n == 8) begin
      foreach (s[i]) pend.push_back(s[i]);
      if (pend.size() == NC) begin
        foreach (pend[i]) word[i*DW +: DW] = pend[i];
        pend.delete();
        done = 1'b1;
      end
    end else begin
      foreach (s[i]) word[i*DW +: DW] = s[i];
      done = 1'b1;
    end
    if (done) begin
      if (ready) begin
        exp_wr   = 1'b1;
        exp_data = word;
        exp_sync = m_armed;
        m_armed  = 1'b0;
      end else begin
        exp_dovf = 1'b1;
        if (exp_cnt < 65535) exp_cnt++;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [NC-1:0] en, input logic valid,
                      input logic [WW-1:0] data, input logic ready);
    @(negedge adc_clk);
    adc_rst          = rst;
    bus.adc_enable   = en;
    bus.adc_valid    = valid;
    bus.adc_data     = data;
    bus.packed_ready = ready;
    model(rst, en, valid, data, ready);
    @(posedge adc_clk);
    #1;
    check("wr_en", 64'(bus.packed_wr_en), 64'(exp_wr));
    check("data",  64'(bus.packed_data),  64'(exp_data));
    check("sync",  64'(bus.packed_sync),  64'(exp_sync));
    check("dovf",  64'(bus.adc_dovf),     64'(exp_dovf));
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
    check("drop_count", 64'(drop_count), 64'(exp_cnt));
`endif
  endtask

  function automatic logic [WW-1:0] ch(input int idx, input logic [DW-1:0] v);
    logic [WW-1:0] d;
    d = '0;
    d[idx*DW +: DW] = v;
    return d;
  endfunction

  initial begin
    logic [NC-1:0] ren;
    bus.adc_enable   = '0;
    bus.adc_valid    = 1'b0;
    bus.adc_data     = '0;
    bus.packed_ready = 1'b1;

    // Reset state
    step(1, '0, 0, '0, 1);
    step(1, '0, 0, '0, 1);
    check("rst_wr",   64'(bus.packed_wr_en), 64'h0);
    check("rst_data", 64'(bus.packed_data),  64'h0);
    check("rst_sync", 64'(bus.packed_sync),  64'h0);
    check("rst_dovf", 64'(bus.adc_dovf),     64'h0);

    // Packed N=1 on ch2
    step(0, 4'b0100, 0, '0, 1);
    for (int i = 1; i <= 4; i++) step(0, 4'b0100, 1, ch(2, 16'(i)), 1);
    check("n1_w0_wr",   64'(bus.packed_wr_en), 64'h1);
    check("n1_w0_data", 64'(bus.packed_data),  64'h0004_0003_0002_0001);
    check("n1_w0_sync", 64'(bus.packed_sync),  64'h1);
    for (int i = 5; i <= 8; i++) step(0, 4'b0100, 1, ch(2, 16'(i)), 1);
    check("n1_w1_data", 64'(bus.packed_data),  64'h0008_0007_0006_0005);
    check("n1_w1_sync", 64'(bus.packed_sync),  64'h0);

    // Packed N=2 on ch0, ch3
    step(0, 4'b1001, 0, '0, 1);
    step(0, 4'b1001, 1, ch(0, 16'h00A0) | ch(3, 16'h00A3), 1);
    check("n2_half_wr", 64'(bus.packed_wr_en), 64'h0);
    step(0, 4'b1001, 1, ch(0, 16'h00B0) | ch(3, 16'h00B3), 1);
    check("n2_wr",   64'(bus.packed_wr_en), 64'h1);
    check("n2_data", 64'(bus.packed_data),  64'h00B3_00B0_00A3_00A0);

    // Padded N=3
    step(0, 4'b0111, 0, '0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 4'b0111, 1, ch(0, 16'h11) | ch(1, 16'h22) | ch(2, 16'h33) | ch(3, 16'hFFFF), 1);
      check("pad_wr",   64'(bus.packed_wr_en), 64'h1);
      check("pad_data", 64'(bus.packed_data),  64'h0000_0033_0022_0011);
    end

    // Enable change mid-word
    step(0, 4'b0100, 0, '0, 1);
    step(0, 4'b0100, 1, ch(2, 16'h00C1), 1);
    step(0, 4'b0100, 1, ch(2, 16'h00C2), 1);
    step(0, 4'b0001, 1, ch(0, 16'h00EE), 1);
    for (int i = 1; i <= 4; i++) step(0, 4'b0001, 1, ch(0, 16'(16'h50 + i)), 1);
    check("chg_data", 64'(bus.packed_data), 64'h0054_0053_0052_0051);
    check("chg_sync", 64'(bus.packed_sync), 64'h1);

    // Overflow with ready low
    step(1, '0, 0, '0, 1);
    step(0, 4'b1111, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1111, 1, {$urandom, $urandom}, 0);
      check("ovf_dovf", 64'(bus.adc_dovf), 64'h1);
    end
`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
    check("ovf_cnt3", 64'(drop_count), 64'd3);
`endif
    step(0, 4'b1111, 1, 64'h0D0C_0B0A_0908_0706, 1);
    check("ovf_wr",   64'(bus.packed_wr_en), 64'h1);
    check("ovf_sync", 64'(bus.packed_sync),  64'h1);

    // Reset mid-word
    step(0, 4'b0001, 0, '0, 1);
    step(0, 4'b0001, 1, ch(0, 16'h0071), 1);
    step(0, 4'b0001, 1, ch(0, 16'h0072), 1);
    step(1, 4'b0001, 1, ch(0, 16'h0073), 1);
    check("rstmid_data", 64'(bus.packed_data), 64'h0);
    check("rstmid_wr",   64'(bus.packed_wr_en), 64'h0);
    step(0, 4'b0001, 0, '0, 1);
    for (int i = 1; i <= 4; i++) step(0, 4'b0001, 1, ch(0, 16'(16'h60 + i)), 1);
    check("rstmid_word", 64'(bus.packed_data), 64'h0064_0063_0062_0061);
    check("rstmid_sync", 64'(bus.packed_sync), 64'h1);

    // Random traffic
    ren = 4'b0011;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) ren = NC'($urandom);
      step(($urandom_range(255) == 0), ren, ($urandom_range(9) < 7),
           {$urandom, $urandom}, ($urandom_range(3) != 0));
    end

`ifdef UTIL_ADC_PACK_DROP_COUNT_EN
    // Saturation of the drop counter
    step(1, '0, 0, '0, 1);
    step(0, 4'b1111, 0, '0, 0);
    for (int i = 0; i < 65537; i++) step(0, 4'b1111, 1, {$urandom, $urandom}, 0);
    check("sat_cnt", 64'(drop_count), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/util_adc_pack.md
# util_adc_pack

Downstream stage of the generic ADC core. It takes per-channel sample sets on adc_clk and compacts only the channels flagged in adc_enable into full-width words for the DMA write FIFO. It reports dropped words back to the core's overflow input through adc_dovf, so software sees the drop in the ADC status register.

## Interface
- NUM_CHANNELS, 2: channel count. Power of two, range 2..8.
- DATA_WIDTH, 16: bits per channel sample.
- adc_clk  in  1  sole clock. All logic runs on its rising edge.
- adc_rst  in  1  reset, synchronous, active-high.
- adc_enable  in  NUM_CHANNELS  per-channel enable from the ADC core's channel registers.
- adc_valid  in  1  sample set on adc_data is valid this cycle.
- adc_data  in  NUM_CHANNELS*DATA_WIDTH  channel i occupies adc_data[i*DATA_WIDTH +: DATA_WIDTH].
- packed_ready  in  1  downstream FIFO can accept a word this cycle.
- packed_wr_en  out  1  packed_data valid. One-cycle strobe per word.
- packed_data  out  NUM_CHANNELS*DATA_WIDTH  packed word. Slot 0 is in the LSBs.
- packed_sync  out  1  high with the first word emitted after reset or after an enable change.
- adc_dovf  out  1  one-cycle pulse when a completed word is dropped.
- drop_count  out  16  saturating dropped-word count. Present only under the macro in Configuration.

## Operation
- N is the popcount of adc_enable, recomputed every cycle.
- **Packed mode** (N is 1, 2, 4 or 8, N ≤ NUM_CHANNELS):
  - Each accepted sample set writes N samples into consecutive slots, in ascending channel index order.
  - Slot pointer p starts at 0 and advances by N per adc_valid.
  - A word completes when p + N == NUM_CHANNELS. p then wraps to 0.
  - Sets per word = NUM_CHANNELS/N.
- **Padded mode** (N not a power of two, e.g. 3 of 4):
  - Every adc_valid completes a word.
  - Enabled samples go in slots 0..N-1. Remaining slots are zero.
- **N == 0**: adc_valid is ignored. No output, no overflow.
- **Enable change**: adc_enable is registered every cycle. If it differs from the previous cycle's value:
  - any partial word is discarded;
  - p resets to 0;
  - the sync flag is armed;
  - an adc_valid in that same cycle is ignored.
- **Completed word**:
  - If packed_ready is high in the completing cycle, the word is emitted.
  - If packed_ready is low, the word is dropped: adc_dovf pulses, drop_count increments, and p still wraps to 0.
  - There is no internal buffering beyond the single assembly word.
- **Sync flag**:
  - Armed by reset and by any enable change.
  - Cleared when an emitted word carries packed_sync = 1.
  - A dropped word does not clear it.
- packed_ready is not sampled when no word completes.

## Timing
- Reset values: packed_wr_en 0, packed_data 0, packed_sync 0, adc_dovf 0, drop_count 0, p 0, sync flag armed, registered enable 0.
- The first cycle after reset with N ≠ 0 counts as an enable change.
- Latency: packed_wr_en, packed_data and packed_sync are registered. They are asserted the cycle after the adc_valid that completes the word.
- adc_dovf is asserted the cycle after the dropping adc_valid.
- Throughput: one adc_valid per cycle sustained. Back-to-back word completions are allowed (N == NUM_CHANNELS, or padded mode).
- packed_data holds its last value when packed_wr_en is low.
- Reset asserted mid-word discards the partial word. Outputs return to reset values on the next edge.
- drop_count saturates at 16'hFFFF and clears only on reset.

## Configuration
- Macro: UTIL_ADC_PACK_DROP_COUNT_EN.
- **Defined**: the drop_count port and its 16-bit saturating counter exist.
- **Undefined**: the drop_count port and counter are absent. adc_dovf behaviour is identical.

## Test plan
- **Packed mode, N=1**:
  - Stimulus: NUM_CHANNELS=4, DATA_WIDTH=16, adc_enable=4'b0100, ch2 data 0x0001..0x0004 on four consecutive adc_valid, packed_ready=1.
  - Response: one packed_wr_en, packed_data=0x0004_0003_0002_0001, packed_sync=1.
  - The next four sets give a word with packed_sync=0.
- **Packed mode, N=2**:
  - Stimulus: adc_enable=4'b1001, sets (ch0,ch3)=(0xA0,0xA3) then (0xB0,0xB3).
  - Response: packed_data=0x00B3_00B0_00A3_00A0, emitted the cycle after the second valid.
- **Padded mode**:
  - Stimulus: adc_enable=4'b0111, set ch0..ch2=0x11,0x22,0x33.
  - Response: a word every valid, packed_data=0x0000_0033_0022_0011.
- **Enable change mid-word**:
  - Stimulus: N=1 with 2 of 4 samples loaded, then adc_enable changes to 4'b0001, then 4 valids.
  - Response: the partial word is never emitted. The next word holds only the post-change samples, with packed_sync=1.
- **Overflow**:
  - Stimulus: adc_enable=4'b1111 and packed_ready=0 for 3 valids, then packed_ready=1.
  - Response: three adc_dovf pulses and drop_count=3 (macro defined). The first emitted word has packed_sync=1.
- **Reset mid-word and saturation**:
  - Stimulus: adc_rst asserted after 2 of 4 samples loaded.
  - Response: all outputs are 0 the next cycle and the following word starts at slot 0.
  - Separately, force 65537 drops: drop_count holds 16'hFFFF.
